mem_port2_arbiter: RTL and testbench
====================================

// Module: mem_port2_arbiter
// PURPOSE
//  Shares the data port (port 2) of the OTTER memory between two requesters: A = pipeline MEM stage,
//  B = DMA/loader. Sequences the memory's synchronous read: issues RDEN2 for one cycle, then holds
//  ADDR2/SIZE/SIGN stable for the data cycle, because sizing/sign-extension and the MMIO select are
//  combinational on those inputs. Sits between both requesters and the memory; IO_WR passes through.
// PARAMETERS
//  A_PRIORITY  1  1 = A always wins ties; 0 = round-robin between A and B on ties
// PORTS
//  CLK        in   1   system clock, all state on rising edge
//  RST        in   1   asynchronous, active-high reset
//  A_REQ      in   1   A requests an access; hold REQ and fields stable until A_ACK
//  A_WE       in   1   1 = write, 0 = read
//  A_ADDR     in   32  byte address
//  A_DIN      in   32  write data
//  A_SIZE     in   2   0 byte, 1 half, 2 word
//  A_SIGN     in   1   1 unsigned, 0 signed (reads)
//  A_ACK      out  1   access accepted this cycle (combinational)
//  A_RVALID   out  1   read data valid on A_RDATA this cycle
//  A_RDATA    out  32  sized/extended read data
//  B_*        --   --  identical set for requester B (B_REQ ... B_RDATA)
//  M_RDEN2    out  1   to memory read enable, port 2
//  M_WE2      out  1   to memory write enable
//  M_ADDR2    out  32  to memory address, port 2
//  M_DIN2     out  32  to memory write data
//  M_SIZE     out  2   to memory size
//  M_SIGN     out  1   to memory sign
//  M_DOUT2    in   32  from memory port-2 read data (valid in data cycle)
//  BUSY       out  1   1 while in a read data cycle
// BEHAVIOUR
//  States: IDLE, RD_A, RD_B. Regs: state, last_grant (A/B), held {addr,size,sign}.
//  Reset: state=IDLE, last_grant=B, held regs=0. All outputs 0 while RST high and in IDLE w/o REQ.
//  IDLE, no REQ: all M_* = 0, ACKs 0, RVALIDs 0.
//  IDLE, one REQ: that requester granted; M_* = its fields, M_WE2=WE, M_RDEN2=~WE, its ACK=1.
//  IDLE, both REQ: A_PRIORITY=1 -> A; else grant requester != last_grant. last_grant<=winner on ACK.
//  Granted write: completes in the ACK cycle; state stays IDLE; next access may issue next cycle.
//  Granted read: latch addr/size/sign; state <= RD_A/RD_B.
//  RD_x (1 cycle): M_ADDR2/M_SIZE/M_SIGN = held regs, M_RDEN2=0, M_WE2=0, M_DIN2=0; x_RVALID=1,
//   x_RDATA=M_DOUT2; no ACKs; BUSY=1; next state IDLE. Read latency: data exactly 1 cycle after ACK.
//  Throughput: writes 1/cycle; reads 1 per 2 cycles; R-then-W: W acked cycle after RVALID.
//  x_RDATA = 0 whenever x_RVALID = 0 (no stale data on either requester).
//  REQ dropped before ACK: no access, no state change. Loser of a tie sees ACK=0 and waits.
//  Round-robin (A_PRIORITY=0): continuous A and B REQ alternate grants A,B,A,B starting with A.
//  Addresses >= 0x0001_0000 (MMIO): same sequencing; memory routes to IO; no special case here.
//  Reset mid-read (RST in RD_x): state -> IDLE immediately; RVALID deasserts; read is lost.
//  No address/alignment checking; unsupported SIZE/offset combos forwarded unchanged.
// TESTING
//  1 A read word @0x100 (mem=0xDEADBEEF) -> A_ACK c0, M_RDEN2=1 c0, A_RVALID c1, A_RDATA=0xDEADBEEF.
//  2 A sb 0x5A @0x101 then lb @0x101 -> write ACK c0, read ACK c1, RVALID c2, RDATA=0x0000005A;
//    lb of 0x80 byte -> 0xFFFFFF80, lbu -> 0x00000080 (M_SIZE/M_SIGN held through data cycle).
//  3 A_PRIORITY=1, A,B REQ reads held 4 reads -> A served every grant, B_ACK=0 until A_REQ drops.
//  4 A_PRIORITY=0, A,B continuous writes -> ACK order A,B,A,B, one per cycle, last_grant toggles.
//  5 B write @0x11000000 -> M_WE2=1, memory IO_WR=1, no memory word changed; B read MMIO -> IO_IN.
//  6 RST pulse during RD_A -> A_RVALID=0 that cycle, state IDLE, all M_* = 0, next A REQ acked.

Source files
------------

// File: rtl/mem_port2_arbiter.sv
// mem_port2_arbiter: shares memory data port 2 between requester A (pipeline MEM) and B (DMA/loader)
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   x_req_i/we/addr/din/size/sign requester x access (x = a, b); hold stable until x_ack_o
//   x_ack_o                      access accepted this cycle (combinational)
//   x_rvalid_o, x_rdata_o        read data one cycle after ack; rdata is 0 otherwise
//   m_rden2_o..m_sign_o          memory port-2 controls; m_dout2_i memory read data
//   busy_o                       high during a read data cycle
module mem_port2_arbiter #(
    parameter bit A_PRIORITY = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        a_req_i,
    input  logic        a_we_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_din_i,
    input  logic [1:0]  a_size_i,
    input  logic        a_sign_i,
    output logic        a_ack_o,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    input  logic        b_req_i,
    input  logic        b_we_i,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_din_i,
    input  logic [1:0]  b_size_i,
    input  logic        b_sign_i,
    output logic        b_ack_o,
    output logic        b_rvalid_o,
    output logic [31:0] b_rdata_o,
    output logic        m_rden2_o,
    output logic        m_we2_o,
    output logic [31:0] m_addr2_o,
    output logic [31:0] m_din2_o,
    output logic [1:0]  m_size_o,
    output logic        m_sign_o,
    input  logic [31:0] m_dout2_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, RD_A, RD_B} state_t;
    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        we;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            addr_q   <= '0;
            size_q   <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        addr_d     = addr_q;
        size_d     = size_q;
        sign_d     = sign_q;
        we         = 1'b0;
        a_ack_o    = 1'b0;
        b_ack_o    = 1'b0;
        a_rvalid_o = 1'b0;
        b_rvalid_o = 1'b0;
        a_rdata_o  = '0;
        b_rdata_o  = '0;
        m_rden2_o  = 1'b0;
        m_we2_o    = 1'b0;
        m_addr2_o  = '0;
        m_din2_o   = '0;
        m_size_o   = '0;
        m_sign_o   = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            IDLE: begin
                // grants are masked while reset is held so nothing leaks onto the memory port
                a_ack_o = ~rst_i & a_req_i & (~b_req_i | A_PRIORITY | last_b_q);
                b_ack_o = ~rst_i & b_req_i & ~a_ack_o;
                if (a_ack_o | b_ack_o) begin
                    we        = a_ack_o ? a_we_i : b_we_i;
                    m_we2_o   = we;
                    m_rden2_o = ~we;
                    m_addr2_o = a_ack_o ? a_addr_i : b_addr_i;
                    m_din2_o  = a_ack_o ? a_din_i : b_din_i;
                    m_size_o  = a_ack_o ? a_size_i : b_size_i;
                    m_sign_o  = a_ack_o ? a_sign_i : b_sign_i;
                    last_b_d  = b_ack_o;
                    if (!we) begin
                        state_d = a_ack_o ? RD_A : RD_B;
                        addr_d  = m_addr2_o;
                        size_d  = m_size_o;
                        sign_d  = m_sign_o;
                    end
                end
            end
            RD_A, RD_B: begin
                // memory sizing and MMIO select are combinational, so keep the fields during data
                m_addr2_o  = addr_q;
                m_size_o   = size_q;
                m_sign_o   = sign_q;
                busy_o     = 1'b1;
                a_rvalid_o = state_q == RD_A;
                b_rvalid_o = state_q == RD_B;
                a_rdata_o  = a_rvalid_o ? m_dout2_i : '0;
                b_rdata_o  = b_rvalid_o ? m_dout2_i : '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port2_arbiter.sv
// tb_mem_port2_arbiter: scoreboard bench for mem_port2_arbiter with a synchronous-read memory model
module tb_mem_port2_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        a_req = 0, a_we = 0, a_sign = 0, b_req = 0, b_we = 0, b_sign = 0;
    logic [31:0] a_addr = 0, a_din = 0, b_addr = 0, b_din = 0, io_in = 0;
    logic [1:0]  a_size = 0, b_size = 0;
    logic        a_ack, a_rvalid, b_ack, b_rvalid, m_rden2, m_we2, m_sign, busy, io_wr;
    logic [31:0] a_rdata, b_rdata, m_addr2, m_din2, m_dout2, raw_q;
    logic [1:0]  m_size;
    logic        rr_a_req = 0, rr_b_req = 0;
    logic        rr_a_ack, rr_a_rv, rr_b_ack, rr_b_rv, rr_rden, rr_we, rr_sign, rr_busy;
    logic [31:0] rr_a_rd, rr_b_rd, rr_addr, rr_din;
    logic [1:0]  rr_size;
    logic [31:0] mem [0:1023];
    logic [31:0] qa[$], qb[$];
    logic        pa = 0, pb = 0;
    int          n_chk = 0, n_ok = 0;

    always #5 clk = ~clk;

    mem_port2_arbiter #(.A_PRIORITY(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_din_i(a_din), .a_size_i(a_size),
        .a_sign_i(a_sign), .a_ack_o(a_ack), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_din_i(b_din), .b_size_i(b_size),
        .b_sign_i(b_sign), .b_ack_o(b_ack), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
        .m_rden2_o(m_rden2), .m_we2_o(m_we2), .m_addr2_o(m_addr2), .m_din2_o(m_din2),
        .m_size_o(m_size), .m_sign_o(m_sign), .m_dout2_i(m_dout2), .busy_o(busy)
    );

    mem_port2_arbiter #(.A_PRIORITY(1'b0)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(rr_a_req), .a_we_i(1'b1), .a_addr_i(32'h10), .a_din_i(32'h1), .a_size_i(2'd2),
        .a_sign_i(1'b0), .a_ack_o(rr_a_ack), .a_rvalid_o(rr_a_rv), .a_rdata_o(rr_a_rd),
        .b_req_i(rr_b_req), .b_we_i(1'b1), .b_addr_i(32'h20), .b_din_i(32'h2), .b_size_i(2'd2),
        .b_sign_i(1'b0), .b_ack_o(rr_b_ack), .b_rvalid_o(rr_b_rv), .b_rdata_o(rr_b_rd),
        .m_rden2_o(rr_rden), .m_we2_o(rr_we), .m_addr2_o(rr_addr), .m_din2_o(rr_din),
        .m_size_o(rr_size), .m_sign_o(rr_sign), .m_dout2_i(32'h0), .busy_o(rr_busy)
    );

    // memory port 2: registered word read, combinational sizing, MMIO above 0x0001_0000
    function automatic logic [31:0] size_ext(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (sz)
            2'd0:    return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'd1:    return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return w;
        endcase
    endfunction

    assign io_wr   = m_we2 & (m_addr2 >= 32'h1_0000);
    assign m_dout2 = (m_addr2 >= 32'h1_0000) ? io_in : size_ext(raw_q, m_addr2[1:0], m_size, m_sign);

    always @(posedge clk) begin
        if (m_we2 && m_addr2 < 32'h1_0000) begin
            case (m_size)
                2'd0:    mem[m_addr2[11:2]][8*m_addr2[1:0] +: 8] <= m_din2[7:0];
                2'd1:    mem[m_addr2[11:2]][{m_addr2[1], 4'b0000} +: 16] <= m_din2[15:0];
                default: mem[m_addr2[11:2]] <= m_din2;
            endcase
        end
        if (m_rden2) raw_q <= mem[m_addr2[11:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: rvalid must follow a read ack by exactly one cycle and pop the queued data
    always @(negedge clk) begin
        if (rst) begin
            pa = 0;
            pb = 0;
        end else begin
            check("a_rvalid", a_rvalid, pa);
            if (a_rvalid) begin
                check("a_q_nonempty", qa.size() > 0, 1);
                if (qa.size() > 0) check("a_rdata", a_rdata, qa.pop_front());
            end else check("a_rdata_zero", a_rdata, 0);
            check("b_rvalid", b_rvalid, pb);
            if (b_rvalid) begin
                check("b_q_nonempty", qb.size() > 0, 1);
                if (qb.size() > 0) check("b_rdata", b_rdata, qb.pop_front());
            end else check("b_rdata_zero", b_rdata, 0);
            pa = a_ack & ~a_we;
            pb = b_ack & ~b_we;
        end
    end

    task automatic drive(input bit is_b, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] din, input logic [1:0] size, input logic sign);
        if (is_b) begin
            b_req = req; b_we = we; b_addr = addr; b_din = din; b_size = size; b_sign = sign;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_din = din; a_size = size; a_sign = sign;
        end
    endtask

    task automatic access(input bit is_b, input logic we, input logic [31:0] addr, input logic [31:0] din,
                          input logic [1:0] size, input logic sign, input logic [31:0] exp);
        drive(is_b, 1, we, addr, din, size, sign);
        if (!we) begin
            if (is_b) qb.push_back(exp);
            else qa.push_back(exp);
        end
        #3;
        check(is_b ? "b_ack" : "a_ack", is_b ? b_ack : a_ack, 1);
        check("m_we2", m_we2, we);
        check("m_rden2", m_rden2, !we);
        check("m_addr2", m_addr2, addr);
        if (we) check("m_din2", m_din2, din);
        tick();
        drive(is_b, 0, 0, 0, 0, 0, 0);
        if (!we) begin
            #3;
            check("rd_busy", busy, 1);
            check("rd_rden_low", m_rden2, 0);
            check("rd_ack_low", a_ack | b_ack, 0);
            check("rd_addr_held", m_addr2, addr);
            check("rd_size_held", m_size, size);
            check("rd_sign_held", m_sign, sign);
            tick();
        end
    endtask

    initial begin
        a_req = 1;
        tick();
        #3;
        check("rst_ack", a_ack, 0);
        check("rst_rden", m_rden2, 0);
        check("rst_addr", m_addr2, 0);
        check("rst_busy", busy, 0);
        a_req = 0;
        tick();
        rst = 0;
        #3;
        check("idle_we", m_we2, 0);
        check("idle_ack", a_ack | b_ack, 0);
        tick();
        // word write then read back
        access(0, 1, 32'h100, 32'hDEADBEEF, 2, 0, 0);
        access(0, 0, 32'h100, 0, 2, 0, 32'hDEADBEEF);
        // byte/half sizing held through the data cycle
        access(0, 1, 32'h101, 32'h5A, 0, 0, 0);
        access(0, 0, 32'h101, 0, 0, 0, 32'h0000005A);
        access(0, 1, 32'h102, 32'h80, 0, 0, 0);
        access(0, 0, 32'h102, 0, 0, 0, 32'hFFFFFF80);
        access(0, 0, 32'h102, 0, 0, 1, 32'h00000080);
        access(0, 0, 32'h102, 0, 1, 0, 32'hFFFFDE80);
        access(0, 0, 32'h100, 0, 1, 1, 32'h00005AEF);
        // fixed priority: A holds its read request and wins every tie
        access(0, 1, 32'h200, 32'h11111111, 2, 0, 0);
        access(1, 1, 32'h204, 32'h22222222, 2, 0, 0);
        drive(0, 1, 0, 32'h200, 0, 2, 0);
        drive(1, 1, 0, 32'h204, 0, 2, 0);
        for (int k = 0; k < 4; k++) begin
            qa.push_back(32'h11111111);
            #3;
            check("pri_a_ack", a_ack, 1);
            check("pri_b_wait", b_ack, 0);
            tick();
            #3;
            check("pri_rd_noack", a_ack | b_ack, 0);
            tick();
        end
        a_req = 0;
        qb.push_back(32'h22222222);
        #3;
        check("pri_b_ack", b_ack, 1);
        check("pri_b_addr", m_addr2, 32'h204);
        tick();
        b_req = 0;
        tick();
        // round-robin: continuous writes from both alternate A,B,A,B
        rr_a_req = 1;
        rr_b_req = 1;
        for (int k = 0; k < 4; k++) begin
            #3;
            check("rr_a_ack", rr_a_ack, (k % 2) == 0);
            check("rr_b_ack", rr_b_ack, (k % 2) == 1);
            check("rr_we", rr_we, 1);
            check("rr_addr", rr_addr, (k % 2) == 0 ? 32'h10 : 32'h20);
            tick();
        end
        rr_a_req = 0;
        rr_b_req = 0;
        // MMIO: write goes to IO only, read returns IO input
        access(1, 1, 32'h0, 32'hA5A5A5A5, 2, 0, 0);
        drive(1, 1, 1, 32'h1100_0000, 32'h12345678, 2, 0);
        #3;
        check("mmio_ack", b_ack, 1);
        check("mmio_we", m_we2, 1);
        check("mmio_io_wr", io_wr, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        access(1, 0, 32'h0, 0, 2, 0, 32'hA5A5A5A5);
        io_in = 32'hCAFEF00D;
        access(1, 0, 32'h1100_0000, 0, 2, 0, 32'hCAFEF00D);
        // reset during the data cycle drops the read
        drive(0, 1, 0, 32'h100, 0, 2, 0);
        #3;
        check("rstrd_ack", a_ack, 1);
        tick();
        rst = 1;
        #1;
        check("rstrd_rvalid", a_rvalid, 0);
        check("rstrd_rdata", a_rdata, 0);
        check("rstrd_busy", busy, 0);
        check("rstrd_addr", m_addr2, 0);
        check("rstrd_rden", m_rden2, 0);
        check("rstrd_noack", a_ack, 0);
        tick();
        rst = 0;
        qa.push_back(32'hDE805AEF);
        #3;
        check("post_rst_ack", a_ack, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
